// File: rtl/pong_ball_engine.sv
// Ball-position engine for the one-dimensional ping-pong game: moves the ball between
// two edges on step ticks, resolves edge hits/misses, keeps score and declares game over.
//
// state  | meaning
// IDLE   | ball waits at the serving edge for serve
// MOVE_R | ball travelling toward RIGHT_EDGE
// MOVE_L | ball travelling toward LEFT_EDGE
// OVER   | game ended; everything frozen until serve
module pong_ball_engine #(
    parameter logic [7:0] LEFT_EDGE  = 8'd0,
    parameter logic [7:0] RIGHT_EDGE = 8'd15,
    parameter logic [3:0] WIN_SCORE  = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serve,
    input  logic       step,
    input  logic       hit_l,
    input  logic       hit_r,
    output logic [7:0] ball_x,
    output logic       dir,
    output logic       in_play,
    output logic       point_l,
    output logic       point_r,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_R = 2'd1,
        MOVE_L = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t     state;
    logic       server;     // 0 = left player serves, 1 = right player serves
    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;
    logic       win_l;
    logic       win_r;

    assign score_l_inc = score_l + 4'd1;
    assign score_r_inc = score_r + 4'd1;
    assign win_l       = (score_l_inc == WIN_SCORE);
    assign win_r       = (score_r_inc == WIN_SCORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            server    <= 1'b0;
            ball_x    <= LEFT_EDGE;
            dir       <= 1'b0;
            in_play   <= 1'b0;
            point_l   <= 1'b0;
            point_r   <= 1'b0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
        end else begin
            point_l <= 1'b0;
            point_r <= 1'b0;
            case (state)
                IDLE: begin
                    // step is deliberately ignored here, even on the serve cycle
                    if (serve) begin
                        state   <= server ? MOVE_L : MOVE_R;
                        in_play <= 1'b1;
                    end
                end
                MOVE_R: begin
                    if (step) begin
                        if (ball_x < RIGHT_EDGE) begin
                            ball_x <= ball_x + 8'd1;
                        end else if (hit_r) begin
                            state  <= MOVE_L;
                            dir    <= 1'b1;
                            ball_x <= ball_x - 8'd1;
                        end else begin
                            point_l   <= 1'b1;
                            score_l   <= score_l_inc;
                            server    <= 1'b1;
                            ball_x    <= RIGHT_EDGE;
                            dir       <= 1'b1;
                            in_play   <= 1'b0;
                            game_over <= win_l;
                            state     <= win_l ? OVER : IDLE;
                        end
                    end
                end
                MOVE_L: begin
                    if (step) begin
                        if (ball_x > LEFT_EDGE) begin
                            ball_x <= ball_x - 8'd1;
                        end else if (hit_l) begin
                            state  <= MOVE_R;
                            dir    <= 1'b0;
                            ball_x <= ball_x + 8'd1;
                        end else begin
                            point_r   <= 1'b1;
                            score_r   <= score_r_inc;
                            server    <= 1'b0;
                            ball_x    <= LEFT_EDGE;
                            dir       <= 1'b0;
                            in_play   <= 1'b0;
                            game_over <= win_r;
                            state     <= win_r ? OVER : IDLE;
                        end
                    end
                end
                OVER: begin
                    // restart keeps server and ball position from the final point
                    if (serve) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        game_over <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized bench for pong_ball_engine against a velocity/goal-edge model of the game;
// directed phases walk the rally, miss, game-over and mid-rally reset scenarios.
module tb_pong_ball_engine;

    localparam int LE = 0;
    localparam int RE = 15;
    localparam int WS = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serve = 1'b0;
    logic       step = 1'b0;
    logic       hit_l = 1'b0;
    logic       hit_r = 1'b0;
    logic [7:0] ball_x;
    logic       dir;
    logic       in_play;
    logic       point_l;
    logic       point_r;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    int total = 0;
    int bad   = 0;

    // model: position, heading (0 right / 1 left), rally flag, scores, game-over
    int m_x, m_dir, m_play, m_pl, m_pr, m_sl, m_sr, m_over;

    always #5 clk = ~clk;

    pong_ball_engine #(
        .LEFT_EDGE (8'(LE)),
        .RIGHT_EDGE(8'(RE)),
        .WIN_SCORE (4'(WS))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .serve    (serve),
        .step     (step),
        .hit_l    (hit_l),
        .hit_r    (hit_r),
        .ball_x   (ball_x),
        .dir      (dir),
        .in_play  (in_play),
        .point_l  (point_l),
        .point_r  (point_r),
        .score_l  (score_l),
        .score_r  (score_r),
        .game_over(game_over)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = LE; m_dir = 0; m_play = 0; m_pl = 0; m_pr = 0;
        m_sl = 0; m_sr = 0; m_over = 0;
    endtask

    // The loser of a point serves, so in IDLE the heading already points away from the edge.
    task automatic model_update(input bit sv, input bit st, input bit hl, input bit hr);
        int vel, goal;
        bit swing;
        m_pl = 0; m_pr = 0;
        if (m_over != 0) begin
            if (sv) begin m_over = 0; m_sl = 0; m_sr = 0; end
        end else if (m_play == 0) begin
            m_play = int'(sv);
        end else if (st) begin
            vel   = (m_dir != 0) ? -1 : 1;
            goal  = (m_dir != 0) ? LE : RE;
            swing = (m_dir != 0) ? hl : hr;
            if (m_x != goal) begin
                m_x += vel;
            end else if (swing) begin
                m_dir = 1 - m_dir;
                m_x  -= vel;
            end else begin
                m_play = 0;
                m_dir  = 1 - m_dir;
                if (goal == RE) begin m_pl = 1; m_sl++; end
                else begin m_pr = 1; m_sr++; end
                if (m_sl == WS || m_sr == WS) m_over = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ball_x"},    int'(ball_x),    m_x);
        chk({tag, ".dir"},       int'(dir),       m_dir);
        chk({tag, ".in_play"},   int'(in_play),   m_play);
        chk({tag, ".point_l"},   int'(point_l),   m_pl);
        chk({tag, ".point_r"},   int'(point_r),   m_pr);
        chk({tag, ".score_l"},   int'(score_l),   m_sl);
        chk({tag, ".score_r"},   int'(score_r),   m_sr);
        chk({tag, ".game_over"}, int'(game_over), m_over);
    endtask

    task automatic tick(input string tag, input bit sv, input bit st, input bit hl, input bit hr);
        serve = sv; step = st; hit_l = hl; hit_r = hr;
        @(posedge clk);
        model_update(sv, st, hl, hr);
        #1;
        check_all(tag);
    endtask

    task automatic reset_now(input string tag);
        serve = 1'b0; step = 1'b0; hit_l = 1'b0; hit_r = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // serve, then a full run to the right edge
        tick("serve_l", 1, 1, 0, 0);
        for (int i = 0; i < RE - LE; i++) tick("run_r", 0, 1, 0, 0);
        chk("run_r_at_edge", int'(ball_x), RE);
        tick("hit_r", 0, 1, 0, 1);
        chk("hit_r_bounce_x", int'(ball_x), RE - 1);
        chk("hit_r_bounce_dir", int'(dir), 1);

        // back to the left edge, return it, then let the right player miss
        for (int i = 0; i < RE - LE - 1; i++) tick("run_l", 0, 1, 0, 0);
        tick("hit_l", 0, 1, 1, 0);
        for (int i = 0; i < RE - LE - 1; i++) tick("run_r2", 0, 1, 0, 0);
        tick("miss_r", 0, 1, 0, 0);
        chk("miss_point_l", int'(point_l), 1);
        chk("miss_score_l", int'(score_l), 1);
        chk("miss_in_play", int'(in_play), 0);
        tick("after_miss", 0, 1, 0, 0);
        chk("point_l_one_cycle", int'(point_l), 0);
        tick("serve_r", 1, 1, 0, 0);
        tick("serve_r_step", 0, 1, 0, 0);
        chk("serve_r_moves_left", int'(ball_x), RE - 1);

        // both swings held: reversals only at the edges
        for (int i = 0; i < 4 * (RE - LE); i++) tick("both_hits", 0, 1, 1, 1);

        // left always hits, right never does: left wins the game
        budget = 3000;
        while (m_over == 0 && budget > 0) begin
            tick("to_over", (m_play == 0), 1, 1, 0);
            budget--;
        end
        chk("over_reached", m_over, 1);
        chk("over_flag", int'(game_over), 1);
        chk("over_score_l", int'(score_l), WS);
        for (int i = 0; i < 10; i++)
            tick("over_frozen", 0, 1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        tick("restart", 1, 1, 0, 0);
        chk("restart_score_l", int'(score_l), 0);
        chk("restart_game_over", int'(game_over), 0);

        // reset in the middle of a rally at ball_x=7
        tick("serve_mid", 1, 0, 0, 0);
        budget = 100;
        while (m_x != 7 && budget > 0) begin
            tick("to_mid", 0, 1, 1, 1);
            budget--;
        end
        chk("mid_reached", m_x, 7);
        reset_now("mid_reset");
        chk("mid_reset_no_point", int'(point_l | point_r), 0);

        // randomized play with occasional resets
        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(2999) == 0) begin
                reset_now("rand_reset");
            end else begin
                tick("rand", ($urandom_range(3) == 0), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

- Sequential ball-position engine for the one-dimensional ping-pong game.
- Generates the 8-bit ball coordinate that the game's position comparators consume.
- Moves the ball between two edges on step ticks and checks for a player hit at each edge.
- Keeps both players' scores and declares game over.

## Interface

Parameters:
- LEFT_EDGE, default 0: leftmost ball coordinate (8-bit value).
- RIGHT_EDGE, default 15: rightmost ball coordinate. Must satisfy LEFT_EDGE < RIGHT_EDGE ≤ 255.
- WIN_SCORE, default 9: score that ends the game. Range 1..15.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serve  input  1  start a rally (IDLE) or restart a game (OVER); level is sampled each cycle.
- step  input  1  one-cycle ball-advance enable from the speed divider.
- hit_l  input  1  left player swing; sampled only at the left edge.
- hit_r  input  1  right player swing; sampled only at the right edge.
- ball_x  output  8  current ball coordinate (registered).
- dir  output  1  direction: 0 = moving right, 1 = moving left.
- in_play  output  1  high while a rally is in progress.
- point_l  output  1  one-cycle pulse when the left player scores.
- point_r  output  1  one-cycle pulse when the right player scores.
- score_l  output  4  left player score.
- score_r  output  4  right player score.
- game_over  output  1  high once either score reaches WIN_SCORE.

## Operation

States:
- IDLE: the ball waits at the serving edge.
- MOVE_R: the ball travels toward RIGHT_EDGE.
- MOVE_L: the ball travels toward LEFT_EDGE.
- OVER: the game has ended.

Server register:
- Reset value is left. The ball waits at LEFT_EDGE with dir=0.
- After each point, the player who lost the point serves next.

IDLE:
- On serve=1, go to MOVE_R if the left player serves, or MOVE_L if the right player serves. in_play goes to 1. ball_x does not change on the serve cycle.
- step is ignored in IDLE, including when serve and step arrive in the same cycle.

MOVE_R, on step=1:
- If ball_x < RIGHT_EDGE: ball_x increments by 1.
- If ball_x == RIGHT_EDGE and hit_r=1: go to MOVE_L, set dir=1, decrement ball_x by 1.
- If ball_x == RIGHT_EDGE and hit_r=0 (miss):
  - pulse point_l and increment score_l;
  - set the server to right, ball_x=RIGHT_EDGE, dir=1, in_play=0;
  - go to IDLE, or to OVER if the new score_l equals WIN_SCORE.

MOVE_L, on step=1: mirror image of MOVE_R. Use LEFT_EDGE, hit_l, point_r and score_r; on a miss the server becomes left and dir becomes 0.

Hit sampling:
- hit_l and hit_r are ignored on any cycle without step, and at any position other than the edge being approached.
- The hit input for the opposite side is always ignored.
- Asserting both hit inputs together is legal; only the relevant one counts.

Other rules:
- serve is ignored in MOVE_R and MOVE_L.
- OVER: game_over=1 and in_play=0; the score, server and ball_x are frozen. serve=1 clears both scores and game_over and returns to IDLE, keeping the current server and ball_x.
- Score arithmetic is 4-bit. A score never exceeds WIN_SCORE, so it never wraps.

## Timing

- Reset is asynchronous and takes effect immediately:
  - ball_x=LEFT_EDGE, dir=0, in_play=0;
  - point_l=0, point_r=0, score_l=0, score_r=0;
  - game_over=0;
  - state IDLE, server left.
- Reset during a rally discards the rally with no point awarded.
- All outputs are registered. Each update appears on the clock edge that samples step or serve, and is visible the following cycle.
- A rally from LEFT_EDGE to RIGHT_EDGE and back takes 2·(RIGHT_EDGE−LEFT_EDGE) steps to return to LEFT_EDGE. The hit is checked on the step that finds ball_x already at the edge, so the ball dwells at each edge for one step interval.
- On a miss, point_x, score_x and game_over update on the same edge. point_x lasts exactly one cycle.

## Test plan

- Reset, then serve=1 for one cycle, then 15 steps with no hit → ball_x counts 0→15, in_play=1, dir=0.
- Continue from that point: one more step with hit_r=1 → ball_x=14, dir=1.
- Serve from the left with hit_r=0 at the edge step → point_l pulses for 1 cycle, score_l=1, ball_x=15, dir=1, in_play=0. The next serve moves the ball left.
- With hit_l=1 and hit_r=1 held high throughout, and steps at non-edge positions → no reversal until an edge is reached; the ball still bounces correctly at both edges.
- Nine left-player points with WIN_SCORE=9 → game_over=1 on the ninth point. Further steps and hits leave all outputs unchanged. serve → scores 0, game_over=0, state IDLE.
- Assert rst_n=0 mid-rally at ball_x=7 → all outputs return to their reset values immediately, with no point pulse.
